// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC sequencing, imem req/ack fetch, skid-buffered output, redirect squash.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MAX_WAIT  = 16,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        pc_src,
  input  logic [31:0] branch_target,
  output logic        valid_out,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic        funct7_bit,
  output logic        fetch_err
);
  typedef enum logic [1:0] {IDLE, FETCH, HOLD, ERR} state_t;
  localparam int CW = $clog2(MAX_WAIT + 1);
  state_t state, state_d;
  logic [31:0] pc, pend_addr, skid_instr, skid_pc;
  logic pend, skid_v, squash, ack, ack_ok, take, misalign, timeout, waiting;
  logic [CW-1:0] wait_cnt;
  assign imem_req   = state == FETCH && !skid_v;
  // An outstanding request keeps its original address even if pc was redirected.
  assign imem_addr  = pend ? pend_addr : pc;
  assign ack        = imem_req & imem_ack;
  assign ack_ok     = ack & ~squash;
  assign take       = valid_out & ~stall;
  assign waiting    = imem_req & ~imem_ack;
  assign misalign   = pc_src & |branch_target[1:0];
  assign timeout    = waiting && wait_cnt == CW'(MAX_WAIT - 1);
  assign opcode     = instr_out[6:0];
  assign funct3     = instr_out[14:12];
  assign funct7_bit = instr_out[30];
  always_comb begin
    state_d = state;
    state_d = state == ERR || misalign || timeout ? ERR :
              pc_src || state == IDLE             ? FETCH :
              ack_ok && valid_out && stall        ? HOLD :
              state == HOLD && take               ? FETCH : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_d;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= RESET_PC;
      pend       <= 1'b0;
      pend_addr  <= '0;
      squash     <= 1'b0;
      wait_cnt   <= '0;
      skid_v     <= 1'b0;
      skid_instr <= '0;
      skid_pc    <= '0;
      valid_out  <= 1'b0;
      instr_out  <= NOP_INSTR;
      pc_out     <= '0;
      fetch_err  <= 1'b0;
    end else if (state_d == ERR) begin
      pend      <= 1'b0;
      squash    <= 1'b0;
      skid_v    <= 1'b0;
      valid_out <= 1'b0;
      instr_out <= NOP_INSTR;
      fetch_err <= 1'b1;
    end else begin
      pend      <= waiting;
      pend_addr <= imem_addr;
      wait_cnt  <= waiting ? wait_cnt + 1'b1 : '0;
      if (pc_src) begin
        pc        <= branch_target;
        valid_out <= 1'b0;
        instr_out <= NOP_INSTR;
        skid_v    <= 1'b0;
        squash    <= waiting;
      end else begin
        if (ack) squash <= 1'b0;
        if (ack_ok) pc <= pc + 32'd4;
        if (ack_ok && (!valid_out || !stall)) begin
          valid_out <= 1'b1;
          instr_out <= imem_rdata;
          pc_out    <= imem_addr;
        end else if (ack_ok) begin
          skid_v     <= 1'b1;
          skid_instr <= imem_rdata;
          skid_pc    <= imem_addr;
        end else if (take) begin
          valid_out <= skid_v;
          instr_out <= skid_v ? skid_instr : NOP_INSTR;
          pc_out    <= skid_v ? skid_pc : pc_out;
          skid_v    <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed scenarios against an address-derived instruction memory.
module tb_instr_fetch_unit;
  logic clk = 0, rst_n = 0;
  logic imem_req, imem_ack, stall, pc_src, valid_out, funct7_bit, fetch_err;
  logic [31:0] imem_addr, imem_rdata, branch_target, instr_out, pc_out;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic ack_mode, ack_force;
  int errors = 0, checks = 0;

  instr_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall), .pc_src(pc_src),
    .branch_target(branch_target), .valid_out(valid_out), .instr_out(instr_out),
    .pc_out(pc_out), .opcode(opcode), .funct3(funct3), .funct7_bit(funct7_bit),
    .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[23:0], 8'h33} ^ 32'h4000_0000;
  endfunction

  assign imem_ack   = ack_mode ? imem_req : ack_force;
  assign imem_rdata = word(imem_addr);

  task automatic do_reset();
    rst_n = 0; stall = 0; pc_src = 0; branch_target = 0; ack_mode = 1; ack_force = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 0; stall = 0; pc_src = 0; branch_target = 0; ack_mode = 1; ack_force = 0;
    #12;
    chk("reset_req", imem_req, 0);
    chk("reset_valid", valid_out, 0);
    chk("reset_instr", instr_out, 32'h13);
    chk("reset_pc_out", pc_out, 0);
    chk("reset_opcode", opcode, 7'h13);
    chk("reset_funct3", funct3, 0);
    chk("reset_f7", funct7_bit, 0);
    chk("reset_err", fetch_err, 0);
  endtask

  task automatic test_stream();
    do_reset();
    @(negedge clk);
    chk("stream_addr0", imem_addr, 0);
    chk("stream_req0", imem_req, 1);
    chk("stream_valid0", valid_out, 0);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk("stream_valid", valid_out, 1);
      chk("stream_pc_out", pc_out, 4 * (i - 1));
      chk("stream_instr", instr_out, word(4 * (i - 1)));
      chk("stream_addr", imem_addr, 4 * i);
      chk("stream_opcode", opcode, instr_out[6:0]);
      chk("stream_funct3", funct3, word(4 * (i - 1)) >> 12 & 7);
      chk("stream_f7", funct7_bit, 1);
    end
  endtask

  task automatic test_stall();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_pc_out", pc_out, 12);
      chk("stall_instr", instr_out, word(12));
      chk("stall_valid", valid_out, 1);
      chk("stall_req", imem_req, 0);
    end
    stall = 0;
    @(negedge clk);
    chk("stall_skid_pc", pc_out, 16);
    chk("stall_skid_instr", instr_out, word(16));
    chk("stall_resume_addr", imem_addr, 20);
    chk("stall_resume_req", imem_req, 1);
    @(negedge clk);
    chk("stall_next_pc", pc_out, 20);
    chk("stall_next_instr", instr_out, word(20));
  endtask

  task automatic test_redirect_pending();
    do_reset();
    repeat (3) @(negedge clk);
    chk("redir_pre_addr", imem_addr, 8);
    stall = 1; ack_mode = 0;
    repeat (2) @(negedge clk);
    chk("redir_wait_addr", imem_addr, 8);
    chk("redir_wait_pc_out", pc_out, 4);
    pc_src = 1; branch_target = 32'h100;
    @(negedge clk);
    pc_src = 0; stall = 0;
    chk("redir_valid", valid_out, 0);
    chk("redir_instr", instr_out, 32'h13);
    chk("redir_old_addr", imem_addr, 8);
    chk("redir_old_req", imem_req, 1);
    ack_mode = 1;
    @(negedge clk);
    chk("redir_drop_valid", valid_out, 0);
    chk("redir_new_addr", imem_addr, 32'h100);
    @(negedge clk);
    chk("redir_first_valid", valid_out, 1);
    chk("redir_first_pc", pc_out, 32'h100);
    chk("redir_first_instr", instr_out, word(32'h100));
  endtask

  task automatic test_redirect_ack();
    do_reset();
    repeat (2) @(negedge clk);
    chk("rack_pre_addr", imem_addr, 4);
    pc_src = 1; branch_target = 32'h40;
    @(negedge clk);
    pc_src = 0;
    chk("rack_valid", valid_out, 0);
    chk("rack_addr", imem_addr, 32'h40);
    chk("rack_req", imem_req, 1);
    @(negedge clk);
    chk("rack_first_valid", valid_out, 1);
    chk("rack_first_pc", pc_out, 32'h40);
    chk("rack_first_instr", instr_out, word(32'h40));
  endtask

  task automatic test_misaligned();
    do_reset();
    repeat (2) @(negedge clk);
    pc_src = 1; branch_target = 32'h102;
    @(negedge clk);
    pc_src = 0;
    chk("mis_err", fetch_err, 1);
    chk("mis_req", imem_req, 0);
    chk("mis_instr", instr_out, 32'h13);
    chk("mis_valid", valid_out, 0);
    repeat (3) @(negedge clk);
    chk("mis_sticky", fetch_err, 1);
  endtask

  task automatic test_timeout();
    do_reset();
    ack_mode = 0;
    @(negedge clk);
    chk("to_req", imem_req, 1);
    repeat (15) @(negedge clk);
    chk("to_not_yet", fetch_err, 0);
    @(negedge clk);
    chk("to_err", fetch_err, 1);
    chk("to_req_off", imem_req, 0);
    repeat (2) @(negedge clk);
    chk("to_sticky", fetch_err, 1);
    rst_n = 0;
    #1;
    chk("to_reset_clears", fetch_err, 0);
  endtask

  task automatic test_async_reset();
    do_reset();
    repeat (3) @(negedge clk);
    chk("ar_pre_valid", valid_out, 1);
    chk("ar_pre_pc", pc_out, 4);
    #2 rst_n = 0;
    #1;
    chk("ar_valid", valid_out, 0);
    chk("ar_pc_out", pc_out, 0);
    chk("ar_instr", instr_out, 32'h13);
    chk("ar_req", imem_req, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("ar_restart_addr", imem_addr, 0);
    @(negedge clk);
    chk("ar_restart_pc", pc_out, 0);
    chk("ar_restart_valid", valid_out, 1);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_pending();
    test_redirect_ack();
    test_misaligned();
    test_timeout();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
